// File: rtl/tia_horizontal_motion.sv
// TIA horizontal motion: five HM registers and a 16-step HMOVE sequencer that emits extra position clocks.
// Outputs are registered; a step's pulse appears 4k+4 cycles after HMOVE; there is no backpressure.
module tia_horizontal_motion (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  input  logic       p0hm,
  input  logic       p1hm,
  input  logic       m0hm,
  input  logic       m1hm,
  input  logic       blhm,
  input  logic       hmove,
  input  logic       hmclr,
  output logic       mc_p0,
  output logic       mc_p1,
  output logic       mc_m0,
  output logic       mc_m1,
  output logic       mc_bl,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [1:0]      phase_q, phase_d;
  logic [4:0]      en_q, en_d;
  logic [4:0]      mc_q, mc_d;
  logic            busy_q, busy_d;
  logic [4:0][3:0] hm_q, hm_d;
  logic [4:0][3:0] key;
  logic [4:0]      wr;

  assign wr = {blhm, m1hm, m0hm, p1hm, p0hm};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      hm_d[i] = hm_q[i];
      if (hmclr)
        hm_d[i] = 4'h0;
      else if (wr[i])
        hm_d[i] = d;
      // Compare against the next-state value so a write lands on the step evaluated right after it.
      key[i] = hm_d[i] ^ 4'b1000;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    en_d    = en_q;
    mc_d    = '0;
    if (hmove) begin
      state_d = S_RUN;
      step_d  = 4'd0;
      phase_d = 2'd0;
      en_d    = '1;
    end else if (state_q == S_RUN) begin
      phase_d = phase_q + 2'd1;
      // Step evaluation is computed one cycle early so the pulse register shows it in phase 3.
      if (phase_q == 2'd2) begin
        for (int i = 0; i < 5; i++) begin
          if (step_q == key[i])
            en_d[i] = 1'b0;
          else if (en_q[i])
            mc_d[i] = 1'b1;
        end
      end
      if (phase_q == 2'd3) begin
        if (step_q == 4'd15) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
          en_d    = '0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      phase_q <= 2'd0;
      en_q    <= '0;
      mc_q    <= '0;
      busy_q  <= 1'b0;
      hm_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      mc_q    <= mc_d;
      busy_q  <= busy_d;
      hm_q    <= hm_d;
    end
  end

  assign mc_p0 = mc_q[0];
  assign mc_p1 = mc_q[1];
  assign mc_m0 = mc_q[2];
  assign mc_m1 = mc_q[3];
  assign mc_bl = mc_q[4];
  assign busy  = busy_q;

endmodule

// File: tb/tb_tia_horizontal_motion.sv
// Bench for tia_horizontal_motion: per-cycle expected outputs are queued by the stimulus, a monitor compares them.
module tb_tia_horizontal_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic [4:0] stb;
  logic       hmove;
  logic       hmclr;
  logic       mc_p0, mc_p1, mc_m0, mc_m1, mc_bl, busy;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] plan_v [0:127];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  int         cnt [5];

  tia_horizontal_motion dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .p0hm  (stb[0]),
    .p1hm  (stb[1]),
    .m0hm  (stb[2]),
    .m1hm  (stb[3]),
    .blhm  (stb[4]),
    .hmove (hmove),
    .hmclr (hmclr),
    .mc_p0 (mc_p0),
    .mc_p1 (mc_p1),
    .mc_m0 (mc_m0),
    .mc_m1 (mc_m1),
    .mc_bl (mc_bl),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d pending=%0d required=0", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Monitor: bit 5 = busy, bits 4..0 = bl, m1, m0, p1, p0.
  always @(negedge clk) begin
    logic [5:0] got;
    exp_t       e;
    got = {busy, mc_bl, mc_m1, mc_m0, mc_p1, mc_p0};
    for (int i = 0; i < 5; i++)
      if (got[i] === 1'b1) cnt[i]++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || got !== e.v) begin
        errors++;
        $display("FAIL out cyc=%0d (slot %0d) got busy,mc=%b required %b", cyc, e.cyc, got, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int obj, input logic [3:0] val);
    d        = val;
    stb      = '0;
    stb[obj] = 1'b1;
    tick();
    stb = '0;
  endtask

  task automatic clr_plan();
    for (int i = 0; i < 128; i++) plan_v[i] = '0;
  endtask

  task automatic add_pulses(input int obj, input int t0, input int n);
    for (int k = 0; k < n; k++) plan_v[t0 + 4*k + 4][obj] = 1'b1;
  endtask

  task automatic add_busy(input int a, input int b);
    for (int i = a; i <= b; i++) plan_v[i][5] = 1'b1;
  endtask

  task automatic plan_all8();
    clr_plan();
    for (int o = 0; o < 5; o++) add_pulses(o, 0, 8);
    add_busy(1, 64);
  endtask

  task automatic push_plan(input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.cyc = cyc + i;
      e.v   = plan_v[i];
      exp_q.push_back(e);
    end
  endtask

  // Window cycle 0 carries hmove; kind: 0 none, 1 HM write, 2 second hmove, 3 reset, at cycle 'at'.
  task automatic run_window(input int len, input int kind, input int at, input int obj, input logic [3:0] val);
    push_plan(len);
    for (int o = 0; o < 5; o++) cnt[o] = 0;
    for (int i = 0; i < len; i++) begin
      hmove = (i == 0) || (kind == 2 && i == at);
      reset = (kind == 3 && i == at);
      stb   = '0;
      d     = val;
      if (kind == 1 && i == at) stb[obj] = 1'b1;
      tick();
    end
    hmove = 1'b0;
    reset = 1'b0;
    stb   = '0;
  endtask

  task automatic chk_counts(input int n0, input int n1, input int n2, input int n3, input int n4);
    int req [5];
    req = '{n0, n1, n2, n3, n4};
    for (int o = 0; o < 5; o++) begin
      checks++;
      if (cnt[o] != req[o]) begin
        errors++;
        $display("FAIL count obj%0d got=%0d required=%0d", o, cnt[o], req[o]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    d     = 4'h0;
    stb   = '0;
    hmove = 1'b0;
    hmclr = 1'b0;
    tick();

    // Reset then a long idle stretch: everything stays low.
    clr_plan();
    push_plan(103);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 101; i++) tick();

    // One value per object: keys 15, 8, 0, 7, 9.
    wr(0, 4'h7);
    wr(1, 4'h0);
    wr(2, 4'h8);
    wr(3, 4'hF);
    wr(4, 4'h1);
    clr_plan();
    add_pulses(0, 0, 15);
    add_pulses(1, 0, 8);
    add_pulses(3, 0, 7);
    add_pulses(4, 0, 9);
    add_busy(1, 64);
    run_window(70, 0, 0, 0, 4'h0);
    chk_counts(15, 8, 0, 7, 9);

    // HMCLR beats a same-cycle HMP0 write and clears the other registers too.
    d     = 4'h7;
    stb   = 5'b00001;
    hmclr = 1'b1;
    tick();
    stb   = '0;
    hmclr = 1'b0;
    plan_all8();
    run_window(70, 0, 0, 0, 4'h0);
    chk_counts(8, 8, 8, 8, 8);

    // HMCLR alone.
    wr(0, 4'h7);
    wr(4, 4'h3);
    hmclr = 1'b1;
    tick();
    hmclr = 1'b0;
    plan_all8();
    run_window(70, 0, 0, 0, 4'h0);
    chk_counts(8, 8, 8, 8, 8);

    // Mid-sequence write of HMP0 = 0xC (key 4) in cycle 10.
    clr_plan();
    add_pulses(0, 0, 4);
    for (int o = 1; o < 5; o++) add_pulses(o, 0, 8);
    add_busy(1, 64);
    run_window(70, 1, 10, 0, 4'hC);
    chk_counts(4, 8, 8, 8, 8);

    // Restart in cycle 20.
    wr(0, 4'h7);
    clr_plan();
    add_pulses(0, 0, 5);
    add_pulses(0, 20, 15);
    for (int o = 1; o < 5; o++) begin
      add_pulses(o, 0, 5);
      add_pulses(o, 20, 8);
    end
    add_busy(1, 84);
    run_window(90, 2, 20, 0, 4'h0);
    chk_counts(20, 13, 13, 13, 13);

    // Reset in cycle 30 kills the sequence and zeroes the registers.
    clr_plan();
    for (int o = 0; o < 5; o++) add_pulses(o, 0, 7);
    add_busy(1, 30);
    run_window(70, 3, 30, 0, 4'h0);
    chk_counts(7, 7, 7, 7, 7);
    plan_all8();
    run_window(70, 0, 0, 0, 4'h0);
    chk_counts(8, 8, 8, 8, 8);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tia_horizontal_motion.md
# tia_horizontal_motion

Downstream consumer of the TIA write-address decode strobes for HMP0, HMP1, HMM0, HMM1, HMBL, HMOVE and HMCLR. The block holds the five 4-bit horizontal-motion registers. On an HMOVE strobe it runs a 16-step motion sequence that emits extra-clock pulses to each object's position counter. Each object receives 8 + signed(HMxx) pulses, in the range 0..15.

## Interface

- No parameters.
- `clk`  in  1  Color clock. All state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `d`  in  4  Write data bus bits D7..D4. Sampled when an HM strobe is high.
- `p0hm`, `p1hm`, `m0hm`, `m1hm`, `blhm`  in  1 each  Write strobes for HMP0, HMP1, HMM0, HMM1, HMBL. Each is a 1-cycle pulse in the `clk` domain.
- `hmove`  in  1  HMOVE strobe, 1-cycle pulse. Starts or restarts the sequence.
- `hmclr`  in  1  HMCLR strobe, 1-cycle pulse. Clears all five HM registers.
- `mc_p0`, `mc_p1`, `mc_m0`, `mc_m1`, `mc_bl`  out  1 each  Extra motion clock pulses, each 1 cycle wide.
- `busy`  out  1  High while a motion sequence is in progress.

## Operation

**Reset values**
- HM registers = 0, enables = 0, step = 0, phase = 0.
- All outputs = 0.

**HM registers**
- On an `xxhm` strobe, the matching register loads `d` at the clock edge.
- `hmclr` loads 0 into all five registers.
- If `hmclr` and an `xxhm` strobe arrive in the same cycle, `hmclr` wins.
- Registers are writable at any time, including mid-sequence. The compare logic always uses the current register value.

**State machine**
- IDLE:
  - `hmove` → RUN.
  - On entry to RUN: step = 0, phase = 0, all five enables = 1.
- RUN:
  - Phase counts 0..3 and wraps. Step increments when phase wraps.
  - A step is evaluated when phase = 3, for each object independently, using key = HM ^ 4'b1000:
    - If step == key: clear that object's enable; no pulse.
    - Else if the enable is set: pulse that object's `mc_*`.
  - After step 15 is evaluated → IDLE. Enables are cleared.
- `hmove` during RUN restarts the sequence (same action as from IDLE). Pulses already emitted are not retracted.
- `reset` in any state returns to IDLE with reset values. No further pulses are emitted.

**Arithmetic**
- HM values are 4-bit two's complement, -8..+7.
- key ranges 0..15. Pulse count = key = 8 + signed(HM).
- Step counter is 4 bits. It never wraps within a sequence; leaving RUN happens at step 15.

## Timing

- `hmove` is high in cycle 0.
- `busy` is high in cycles 1..64 inclusive and low in cycle 65, absent a restart.
- Step k (k = 0..15) pulse, when emitted, is high in exactly cycle 4k+4.
  - Pulses are at least 4 cycles apart per object.
  - The last possible pulse is in cycle 60, for step 14 with key = 15.
- HM write in cycle c takes effect for any step evaluated in cycle c+1 or later.
- A restart `hmove` in cycle r re-times all pulses relative to r.
- All outputs are registered. No combinational path from any input to any output.

## Test plan

- **Reset and idle.** Reset, then idle 100 cycles → all `mc_*` = 0, `busy` = 0.
- **Per-value pulse counts.** Write HMP0 = 0x7, HMP1 = 0x0, HMM0 = 0x8 (-8), HMM1 = 0xF (-1), HMBL = 0x1; then `hmove` in cycle 0.
  - Required pulse counts: `mc_p0` 15, `mc_p1` 8, `mc_m0` 0, `mc_m1` 7, `mc_bl` 9.
  - `mc_p1` pulses in cycles 4, 8, …, 32.
  - `busy` is high in cycles 1..64.
- **HMCLR priority.** Assert `hmclr` and `p0hm` with d = 0x7 in the same cycle, then `hmove` → `mc_p0` gives 8 pulses. Also check `hmclr` alone zeroes all registers.
- **Mid-sequence write.** HMP0 = 0x0, `hmove` in cycle 0; write HMP0 = 0xC (key 4) in cycle 10 → `mc_p0` pulses in cycles 4, 8, 12, 16 only (4 pulses).
- **Restart.** HMP0 = 0x7, `hmove` in cycle 0 and again in cycle 20 → `mc_p0` pulses at 4, 8, 12, 16, 20, then 24, 28, …, 80. `busy` falls after cycle 84.
- **Reset mid-sequence.** `reset` in cycle 30 of a sequence → no `mc_*` pulses after cycle 30, `busy` = 0 from cycle 31, HM registers read back 0 (next `hmove` gives 8 pulses per object).
